// File: rtl/mem_resp_tracker_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_tracker_if
//  Brief    : Request / dmem-response / ROB-completion bundle for the tracker.
//  Revision : 1.0
// ============================================================================
interface mem_resp_tracker_if #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
);
    logic                       branch_mispredict;
    logic                       req_valid;
    logic                       req_ready;
    logic [ROB_W-1:0]           req_rob_id;
    logic [31:0]                req_addr;
    logic [2:0]                 req_funct3;
    logic [3:0]                 req_rmask;
    logic [3:0]                 req_wmask;
    logic                       dmem_resp;
    logic [31:0]                dmem_rdata;
    logic                       resp_valid;
    logic [ROB_W-1:0]           resp_rob_id;
    logic                       resp_store;
    logic [31:0]                resp_rd_data;
    logic [31:0]                resp_dmem_rdata;
    logic [$clog2(DEPTH):0]     outstanding;
    logic                       err_spurious;

    // Tracker side
    modport slave (
        input  branch_mispredict, req_valid, req_rob_id, req_addr, req_funct3,
               req_rmask, req_wmask, dmem_resp, dmem_rdata,
        output req_ready, resp_valid, resp_rob_id, resp_store, resp_rd_data,
               resp_dmem_rdata, outstanding, err_spurious
    );

    // Issuer / memory side
    modport master (
        output branch_mispredict, req_valid, req_rob_id, req_addr, req_funct3,
               req_rmask, req_wmask, dmem_resp, dmem_rdata,
        input  req_ready, resp_valid, resp_rob_id, resp_store, resp_rd_data,
               resp_dmem_rdata, outstanding, err_spurious
    );
endinterface
`default_nettype wire

// File: rtl/mem_resp_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : mem_resp_tracker
//  Brief    : Tracks in-flight dmem requests, formats load data, kills on flush.
//  Revision : 1.0
// ============================================================================
module mem_resp_tracker #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_resp_tracker_if.slave  bus
);
    localparam int                PTR_W  = $clog2(DEPTH);
    localparam int                CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

    logic [ROB_W-1:0] rob_q   [DEPTH];
    logic [1:0]       addr_q  [DEPTH];
    logic [2:0]       f3_q    [DEPTH];
    logic [DEPTH-1:0] store_q;
    logic [DEPTH-1:0] killed_q, killed_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic             w_ready, w_accept, w_pop, w_live;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_fmt;
    logic             w_unused_ok;

    assign w_unused_ok = &{1'b0, bus.req_rmask, bus.req_addr[31:2]};

    always_comb begin
        w_ready  = count_q < C_FULL;
        w_accept = bus.req_valid && w_ready;
        w_pop    = bus.dmem_resp && (count_q != '0);
        w_live   = w_pop && !killed_q[head_q] && !bus.branch_mispredict;

        head_d = w_pop    ? head_q + PTR_W'(1) : head_q;
        tail_d = w_accept ? tail_q + PTR_W'(1) : tail_q;
        unique case ({w_accept, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q || (bus.dmem_resp && (count_q == '0));

        // A flush marks only entries between head and head+count; the slot
        // accepted this same cycle is covered by the write below.
        killed_d = killed_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.branch_mispredict &&
                ({1'b0, PTR_W'(i) - head_q} < count_q)) begin
                killed_d[i] = 1'b1;
            end
        end
        if (w_accept) begin
            killed_d[tail_q] = bus.branch_mispredict;
        end
    end

    always_comb begin
        unique case (addr_q[head_q])
            2'd0:    w_byte = bus.dmem_rdata[7:0];
            2'd1:    w_byte = bus.dmem_rdata[15:8];
            2'd2:    w_byte = bus.dmem_rdata[23:16];
            default: w_byte = bus.dmem_rdata[31:24];
        endcase
        w_half = addr_q[head_q][1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        unique case (f3_q[head_q])
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_fmt = bus.dmem_rdata;
            3'b100:  w_fmt = {24'd0, w_byte};
            3'b101:  w_fmt = {16'd0, w_half};
            default: w_fmt = 32'd0;
        endcase
    end

    assign bus.req_ready       = w_ready;
    assign bus.outstanding     = count_q;
    assign bus.err_spurious    = err_q;
    assign bus.resp_valid      = w_live;
    assign bus.resp_rob_id     = w_live ? rob_q[head_q] : '0;
    assign bus.resp_store      = w_live && store_q[head_q];
    assign bus.resp_rd_data    = (w_live && !store_q[head_q]) ? w_fmt : 32'd0;
    assign bus.resp_dmem_rdata = (w_live && !store_q[head_q]) ? bus.dmem_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            killed_q <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            killed_q <= killed_d;
            err_q    <= err_d;
        end
    end

    // Payload needs no reset: it is only read while the slot is occupied.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            rob_q[tail_q]   <= bus.req_rob_id;
            addr_q[tail_q]  <= bus.req_addr[1:0];
            f3_q[tail_q]    <= bus.req_funct3;
            store_q[tail_q] <= bus.req_wmask != 4'd0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_resp_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_resp_tracker
//  Brief    : Self-checking bench for mem_resp_tracker (vectors + reference queue).
//  Revision : 1.0
// ============================================================================
module tb_mem_resp_tracker;
    localparam int DEPTH = 4;
    localparam int ROB_W = 5;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mem_resp_tracker_if #(.DEPTH(DEPTH), .ROB_W(ROB_W)) bus ();
    mem_resp_tracker #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ROB_W-1:0] rob;
        logic [1:0]       a;
        logic [2:0]       f3;
        bit               st;
        bit               k;
    } ent_t;
    ent_t mq[$];
    bit   merr;

    logic             obs_valid, obs_store, obs_ready, obs_err;
    logic [ROB_W-1:0] obs_rob;
    logic [31:0]      obs_rd, obs_raw;
    int               obs_out;

    typedef struct {
        bit rv; logic [ROB_W-1:0] rob; logic [1:0] a; logic [2:0] f3; logic [3:0] wm;
        bit dr; logic [31:0] rdata;
        bit e_valid; logic [ROB_W-1:0] e_rob; bit e_store; logic [31:0] e_rd; bit e_ready; int e_out;
    } vec_t;
    vec_t tq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Load formatting from the ISA definition using plain arithmetic.
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
        int unsigned b, h;
        b = (d >> (8 * a)) & 32'hFF;
        h = (d >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b010:  return d;
            3'b100:  return b;
            3'b101:  return h;
            default: return 32'd0;
        endcase
    endfunction

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input bit rv, input logic [ROB_W-1:0] rob, input logic [1:0] a,
                        input logic [2:0] f3, input logic [3:0] wm, input bit bm,
                        input bit dr, input logic [31:0] rdata);
        logic [31:0] hi;
        int          n;
        bit          pop, acc, ev;
        ent_t        e;
        hi = $urandom();
        bus.req_valid         = rv;
        bus.req_rob_id        = rob;
        bus.req_addr          = {hi[31:2], a};
        bus.req_funct3        = f3;
        bus.req_wmask         = wm;
        bus.req_rmask         = (wm != 0) ? 4'h0 : 4'hF;
        bus.branch_mispredict = bm;
        bus.dmem_resp         = dr;
        bus.dmem_rdata        = rdata;
        n   = mq.size();
        acc = rv && (n < DEPTH);
        pop = dr && (n > 0);
        ev  = pop && !mq[0].k && !bm;
        @(negedge clk);
        obs_valid = bus.resp_valid;  obs_rob = bus.resp_rob_id;  obs_store = bus.resp_store;
        obs_rd = bus.resp_rd_data;   obs_raw = bus.resp_dmem_rdata;
        obs_ready = bus.req_ready;   obs_out = int'(bus.outstanding); obs_err = bus.err_spurious;
        chk("req_ready", obs_ready, n < DEPTH);
        chk("outstanding", obs_out, n);
        chk("err_spurious", obs_err, merr);
        chk("resp_valid", obs_valid, ev);
        chk("resp_rob_id", obs_rob, ev ? mq[0].rob : 0);
        chk("resp_store", obs_store, ev && mq[0].st);
        chk("resp_rd_data", obs_rd, (ev && !mq[0].st) ? fmt(mq[0].f3, mq[0].a, rdata) : 0);
        chk("resp_dmem_rdata", obs_raw, (ev && !mq[0].st) ? rdata : 0);
        @(posedge clk);
        if (dr && n == 0) merr = 1'b1;
        if (pop) void'(mq.pop_front());
        if (bm) foreach (mq[i]) mq[i].k = 1'b1;
        if (acc) begin
            e.rob = rob; e.a = a; e.f3 = f3; e.st = (wm != 0); e.k = bm;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic push(input logic [ROB_W-1:0] rob, input logic [1:0] a, input logic [2:0] f3, input logic [3:0] wm);
        step(1, rob, a, f3, wm, 0, 0, 0);
    endtask
    task automatic resp(input logic [31:0] d);
        step(0, 0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b1; bus.dmem_resp = 1'b1; bus.branch_mispredict = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 1'b0; bus.dmem_resp = 1'b0; bus.branch_mispredict = 1'b0;
        mq.delete();
        merr = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_valid", bus.resp_valid, 0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_err", bus.err_spurious, 0);
        chk("rst_rd_data", bus.resp_rd_data, 0);
        @(posedge clk); #1;
    endtask

    task automatic addv(input bit rv, input logic [ROB_W-1:0] rob, input logic [1:0] a, input logic [2:0] f3,
                        input logic [3:0] wm, input bit dr, input logic [31:0] rdata, input bit ev,
                        input logic [ROB_W-1:0] erob, input bit est, input logic [31:0] erd, input int eout);
        vec_t v;
        v.rv = rv; v.rob = rob; v.a = a; v.f3 = f3; v.wm = wm; v.dr = dr; v.rdata = rdata;
        v.e_valid = ev; v.e_rob = erob; v.e_store = est; v.e_rd = erd; v.e_ready = 1; v.e_out = eout;
        tq.push_back(v);
    endtask

    initial begin
        logic [2:0] f3s [6];
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
        rst = 1'b1; merr = 1'b0;
        bus.req_valid = 0; bus.req_rob_id = 0; bus.req_addr = 0; bus.req_funct3 = 0;
        bus.req_rmask = 0; bus.req_wmask = 0; bus.branch_mispredict = 0;
        bus.dmem_resp = 0; bus.dmem_rdata = 0;
        do_reset();

        // rv rob a f3 wm dr rdata | valid rob store rd out
        addv(1, 3, 0, 3'b010, 0, 0, 0,            0, 0,  0, 32'h0, 0);
        addv(0, 0, 0, 0,      0, 0, 0,            0, 0,  0, 32'h0, 1);
        addv(0, 0, 0, 0,      0, 1, 32'hDEADBEEF, 1, 3,  0, 32'hDEADBEEF, 1);
        addv(0, 0, 0, 0,      0, 0, 0,            0, 0,  0, 32'h0, 0);
        addv(1, 5, 1, 3'b000, 0, 0, 32'h80F17F01, 0, 0,  0, 32'h0, 0);
        addv(1, 6, 3, 3'b000, 0, 1, 32'h80F17F01, 1, 5,  0, 32'h0000007F, 1);
        addv(1, 7, 3, 3'b100, 0, 1, 32'h80F17F01, 1, 6,  0, 32'hFFFFFF80, 1);
        addv(1, 8, 2, 3'b001, 0, 1, 32'h80F17F01, 1, 7,  0, 32'h00000080, 1);
        addv(1, 9, 0, 3'b101, 0, 1, 32'h80F17F01, 1, 8,  0, 32'hFFFF80F1, 1);
        addv(0, 0, 0, 0,      0, 1, 32'h80F17F01, 1, 9,  0, 32'h00007F01, 1);
        addv(1, 10, 0, 3'b010, 4'hF, 0, 0,        0, 0,  0, 32'h0, 0);
        addv(1, 11, 1, 3'b011, 0, 1, 32'h12345678, 1, 10, 1, 32'h0, 1);
        addv(0, 0, 0, 0,      0, 1, 32'h12345678, 1, 11, 0, 32'h0, 1);
        addv(0, 0, 0, 0,      0, 0, 0,            0, 0,  0, 32'h0, 0);
        foreach (tq[i]) begin
            step(tq[i].rv, tq[i].rob, tq[i].a, tq[i].f3, tq[i].wm, 0, tq[i].dr, tq[i].rdata);
            chk($sformatf("vec%0d_valid", i), obs_valid, tq[i].e_valid);
            chk($sformatf("vec%0d_rob", i), obs_rob, tq[i].e_rob);
            chk($sformatf("vec%0d_store", i), obs_store, tq[i].e_store);
            chk($sformatf("vec%0d_rd", i), obs_rd, tq[i].e_rd);
            chk($sformatf("vec%0d_ready", i), obs_ready, tq[i].e_ready);
            chk($sformatf("vec%0d_out", i), obs_out, tq[i].e_out);
        end

        // Fill to full, attempt an accept while full, then drain; three rounds for wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k <= 4; k++) push(5'(k), 2'(k), 3'b010, (k == 3) ? 4'hF : 4'h0);
            step(1, 9, 0, 3'b010, 0, 0, 1, 32'hA5A5_0000 + r);
            chk("full_ready", obs_ready, 0);
            chk("full_first_rob", obs_rob, 1);
            for (int k = 2; k <= 4; k++) begin
                resp($urandom());
                chk("drain_rob", obs_rob, k);
                chk("drain_store", obs_store, k == 3);
            end
            idle();
            chk("drained_out", obs_out, 0);
        end

        // Flush with a fourth request accepted in the flush cycle.
        push(1, 0, 3'b010, 0); push(2, 0, 3'b010, 0); push(3, 0, 3'b010, 0);
        step(1, 4, 0, 3'b010, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            resp($urandom());
            chk("killed_no_valid", obs_valid, 0);
        end
        push(12, 0, 3'b010, 0);
        resp(32'h0BAD_F00D);
        chk("post_flush_valid", obs_valid, 1);
        chk("post_flush_rob", obs_rob, 12);

        // Steady push+pop at count 2.
        push(20, 0, 3'b010, 0); push(21, 0, 3'b010, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 5'(22 + k), 0, 3'b010, 0, 0, 1, $urandom());
            chk("steady_out", obs_out, 2);
            chk("steady_rob", obs_rob, 20 + k);
        end
        resp(0); resp(0);

        // Spurious response, then reset mid-flight.
        resp(32'h1);
        idle();
        chk("spurious_sticky", obs_err, 1);
        do_reset();
        push(1, 0, 3'b010, 0); push(2, 0, 3'b010, 0);
        do_reset();
        resp(32'h2);
        idle();
        chk("spurious_after_rst", obs_err, 1);

        // Randomized traffic against the reference queue.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 9) < 6, 5'($urandom()), 2'($urandom()), f3s[$urandom_range(0, 5)],
                      ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 9) < 5, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_resp_tracker.md
# mem_resp_tracker

Parametrised data-memory response tracker for the out-of-order core's load/store path. It allows up to `DEPTH` loads/stores to be in flight to dmem at once, matches in-order dmem responses to their ROB entries, formats load data, and publishes a completion to the ROB. On a branch mispredict it kills all in-flight requests while still absorbing their late dmem responses, so no stale completion ever reaches the ROB.

## Interface
- `DEPTH`, 4: maximum outstanding requests; power of two, ≥2.
- `ROB_W`, `ROB_ID_SIZE`: ROB id width.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `branch_mispredict` in 1: flush pulse.
- `req_valid` in 1: issuer presents a request; the issuer drives dmem in the same cycle it is accepted.
- `req_ready` out 1: tracker can accept a request.
- `req_rob_id` in ROB_W: ROB entry of the request.
- `req_addr` in 32: byte address; only [1:0] is stored.
- `req_funct3` in 3: load type (lb/lh/lw/lbu/lhu).
- `req_rmask` in 4, `req_wmask` in 4: dmem masks; wmask≠0 means store.
- `dmem_resp` in 1: one response, in request order.
- `dmem_rdata` in 32: raw read data, valid with `dmem_resp`.
- `resp_valid` out 1: completion to ROB this cycle.
- `resp_rob_id` out ROB_W, `resp_store` out 1, `resp_rd_data` out 32 (formatted), `resp_dmem_rdata` out 32 (raw).
- `outstanding` out $clog2(DEPTH)+1: live+killed entries in flight.
- `err_spurious` out 1: sticky; `dmem_resp` arrived with nothing in flight.

## Operation
- Circular FIFO of `DEPTH` entries: {rob_id, addr[1:0], funct3, store, killed}; head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; count of $clog2(DEPTH)+1 bits.
- Accept = `req_valid && req_ready`; writes entry at tail with killed=0, tail++.
- `req_ready` = count < DEPTH; registered state only, no combinational path from `dmem_resp`.
- `dmem_resp` with count>0: pop head. If head not killed and no flush this cycle: `resp_valid`=1, rob_id from entry, `resp_store`=entry.store.
- Loads: `resp_dmem_rdata`=`dmem_rdata`; `resp_rd_data` by funct3 using addr[1:0]: lb sign-extends byte addr, lbu zero-extends it; lh/lhu take half addr[1] sign/zero-extended; lw passes through; other funct3 → 0.
- Stores: `resp_rd_data`=0, `resp_dmem_rdata`=0.
- When `resp_valid`=0 all resp data outputs are 0.
- Killed head popped silently (no `resp_valid`).
- `branch_mispredict`: set killed on every occupied entry and on any entry accepted that same cycle; pointers and count are kept so late responses drain. `resp_valid` forced 0 that cycle, head still popped if `dmem_resp`.
- `dmem_resp` with count==0: ignored, `err_spurious` set until reset.
- Push and pop in same cycle: count unchanged, both pointers advance. At full, no push is possible because `req_ready`=0.

## Timing
- Reset (sync, `rst`=1 at edge): head=tail=count=0, all killed=0, `err_spurious`=0. Resulting outputs: `req_ready`=1, `resp_valid`=0, resp data 0, `outstanding`=0.
- Reset wins over every other input in the same cycle.
- Completion is combinational in the `dmem_resp` cycle (0-cycle latency from response); state updates at the following edge.
- Throughput: one accept and one completion per cycle.
- `outstanding` and `req_ready` reflect registered count only.

## Test plan
- Reset, then accept lw rob 3 at addr 0x100; `dmem_resp` 2 cycles later with rdata 0xDEADBEEF → `resp_valid`=1, rob 3, `resp_rd_data`=0xDEADBEEF, `resp_store`=0, `outstanding` returns to 0.
- Format sweep with rdata 0x80F17F01: lb addr[1:0]=1 → 0x0000007F; lb addr 3 → 0xFFFFFF80; lbu addr 3 → 0x00000080; lh addr 2 → 0xFFFF80F1; lhu addr 0 → 0x00007F01.
- Issue 4 requests (rob 1-4, one a store) with no response → `req_ready`=0 at count 4; response in the same cycle as `req_valid` → no accept. Then 4 responses → rob 1,2,3,4 in order with the store flagged, with wrap-around checked over 3 fill/drain rounds.
- Three requests in flight, `branch_mispredict` asserted with a 4th request accepted the same cycle → next four `dmem_resp` produce no `resp_valid`. A new request afterward completes normally with its own rob id.
- Simultaneous accept and response each cycle for 10 cycles at count 2 → count stays 2, completions in issue order.
- `dmem_resp` at count 0 → no `resp_valid`, `err_spurious`=1 until `rst`. Asserting `rst` mid-flight with 2 outstanding → count=0, a later response flags `err_spurious`.
